// File: rtl/framebuffer_pingpong.sv
// Ping-pong frame store controller: graphics writes go to the back BRAM, VGA reads
// come from the front BRAM, and a swap request waits until the back frame is complete.
module framebuffer_pingpong #(
    parameter int                 ADDR_W       = 17,
    parameter int                 DATA_W       = 15,
    parameter int                 FRAME_PIXELS = 38400,
    parameter logic [DATA_W-1:0]  BLANK_COLOR  = 15'h0000
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              toggle,
    input  logic              wen,
    input  logic [ADDR_W-1:0] graphics_addr,
    input  logic [DATA_W-1:0] graphics_color,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_color,
    output logic [ADDR_W-1:0] buffer0_address,
    output logic [ADDR_W-1:0] buffer1_address,
    output logic [DATA_W-1:0] buffer0_din,
    output logic [DATA_W-1:0] buffer1_din,
    input  logic [DATA_W-1:0] buffer0_dout,
    input  logic [DATA_W-1:0] buffer1_dout,
    output logic              buffer0_ce,
    output logic              buffer1_ce,
    output logic              buffer0_we,
    output logic              buffer1_we,
    output logic              front_sel,
    output logic              swap_pending,
    output logic [7:0]        swap_count,
    output logic              wr_range_err
);

    localparam logic [ADDR_W-1:0] FP_END    = ADDR_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [0:0] {IDLE, PENDING} state_t;

    state_t state;
    logic   toggle_d;
    logic   frame_done;
    logic   sel_d;
    logic   rng_d;

    logic wr_in_range;
    logic wr_accept;
    logic req;
    logic swap_go;

    assign wr_in_range = (graphics_addr < FP_END);
    assign wr_accept   = wen && wr_in_range;
    assign req         = toggle && !toggle_d;
    assign swap_go     = (state == PENDING) && frame_done;

    // Front buffer is a pure read port; back buffer carries the graphics writes.
    always_comb begin
        buffer0_address = vga_addr;
        buffer0_din     = '0;
        buffer0_ce      = 1'b1;
        buffer0_we      = 1'b0;
        buffer1_address = vga_addr;
        buffer1_din     = '0;
        buffer1_ce      = 1'b1;
        buffer1_we      = 1'b0;
        if (front_sel) begin
            buffer0_address = graphics_addr;
            buffer0_din     = graphics_color;
            buffer0_ce      = wen;
            buffer0_we      = wr_accept;
        end else begin
            buffer1_address = graphics_addr;
            buffer1_din     = graphics_color;
            buffer1_ce      = wen;
            buffer1_we      = wr_accept;
        end
    end

    // Swap FSM; swap clears frame_done even if the last pixel lands on the same edge,
    // since that write went into the buffer that is becoming front.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            toggle_d     <= 1'b0;
            frame_done   <= 1'b0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_count   <= 8'd0;
            wr_range_err <= 1'b0;
        end else begin
            toggle_d <= toggle;
            if (wen && !wr_in_range)
                wr_range_err <= 1'b1;
            if (swap_go) begin
                front_sel    <= ~front_sel;
                frame_done   <= 1'b0;
                swap_count   <= swap_count + 8'd1;
                state        <= IDLE;
                swap_pending <= 1'b0;
            end else begin
                if (wr_accept && (graphics_addr == LAST_ADDR))
                    frame_done <= 1'b1;
                if ((state == IDLE) && req) begin
                    state        <= PENDING;
                    swap_pending <= 1'b1;
                end
            end
        end
    end

    // Read path: sel_d pins each read to the buffer that was front when it was issued.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sel_d     <= 1'b0;
            rng_d     <= 1'b0;
            vga_color <= '0;
        end else begin
            sel_d     <= front_sel;
            rng_d     <= (vga_addr < FP_END);
            vga_color <= rng_d ? (sel_d ? buffer1_dout : buffer0_dout) : BLANK_COLOR;
        end
    end

endmodule

// File: tb/tb_framebuffer_pingpong.sv
// Randomised bench for framebuffer_pingpong against a frame-level reference model.
module tb_framebuffer_pingpong;

    localparam int          AW    = 17;
    localparam int          DW    = 15;
    localparam int          FP    = 38400;
    localparam logic [14:0] BLANK = 15'h0000;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          toggle = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] graphics_addr = '0;
    logic [DW-1:0] graphics_color = '0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_color;
    logic [AW-1:0] buffer0_address, buffer1_address;
    logic [DW-1:0] buffer0_din, buffer1_din;
    logic [DW-1:0] buffer0_dout = '0, buffer1_dout = '0;
    logic          buffer0_ce, buffer1_ce, buffer0_we, buffer1_we;
    logic          front_sel, swap_pending, wr_range_err;
    logic [7:0]    swap_count;

    int errors = 0;
    int checks = 0;

    framebuffer_pingpong dut (
        .clk(clk), .rst_b(rst_b), .toggle(toggle), .wen(wen),
        .graphics_addr(graphics_addr), .graphics_color(graphics_color),
        .vga_addr(vga_addr), .vga_color(vga_color),
        .buffer0_address(buffer0_address), .buffer1_address(buffer1_address),
        .buffer0_din(buffer0_din), .buffer1_din(buffer1_din),
        .buffer0_dout(buffer0_dout), .buffer1_dout(buffer1_dout),
        .buffer0_ce(buffer0_ce), .buffer1_ce(buffer1_ce),
        .buffer0_we(buffer0_we), .buffer1_we(buffer1_we),
        .front_sel(front_sel), .swap_pending(swap_pending),
        .swap_count(swap_count), .wr_range_err(wr_range_err)
    );

    always #5 clk = ~clk;

    // BRAM models: single port, read-first, one-cycle latency
    logic [DW-1:0] mem0 [FP];
    logic [DW-1:0] mem1 [FP];
    always @(posedge clk) begin
        if (buffer0_ce) begin
            if (buffer0_we && buffer0_address < FP) mem0[buffer0_address] <= buffer0_din;
            buffer0_dout <= (buffer0_address < FP) ? mem0[buffer0_address] : '0;
        end
        if (buffer1_ce) begin
            if (buffer1_we && buffer1_address < FP) mem1[buffer1_address] <= buffer1_din;
            buffer1_dout <= (buffer1_address < FP) ? mem1[buffer1_address] : '0;
        end
    end

    // Reference model: frame contents per buffer, front index, pending flag, etc.
    logic [DW-1:0] rf0 [FP];
    logic [DW-1:0] rf1 [FP];
    bit            m_front, m_pend, m_done, m_err, m_tog;
    logic [7:0]    m_cnt;
    logic [DW-1:0] m_color;
    logic [DW-1:0] m_q[$];

    task automatic model_reset();
        m_front = 0; m_pend = 0; m_done = 0; m_err = 0; m_tog = 0;
        m_cnt = 8'd0; m_color = '0;
        m_q.delete();
        m_q.push_back(BLANK);
    endtask

    task automatic model_step();
        bit req, acc, swap;
        logic [DW-1:0] rexp;
        if (!rst_b) begin
            model_reset();
            return;
        end
        req   = toggle && !m_tog;
        m_tog = toggle;
        acc   = wen && (graphics_addr < FP);
        if (vga_addr < FP) rexp = m_front ? rf1[vga_addr] : rf0[vga_addr];
        else               rexp = BLANK;
        m_q.push_back(rexp);
        m_color = m_q.pop_front();
        if (wen && graphics_addr >= FP) m_err = 1;
        if (acc) begin
            if (m_front) rf0[graphics_addr] = graphics_color;
            else         rf1[graphics_addr] = graphics_color;
        end
        swap = m_pend && m_done;
        if (acc && graphics_addr == FP - 1) m_done = 1;
        if (swap) begin
            m_front = !m_front; m_done = 0; m_cnt = m_cnt + 8'd1; m_pend = 0;
        end else if (req) begin
            m_pend = 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 0;
        model_reset();
        repeat (3) cycle();
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got=%0b exp=0", front_sel); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%0b exp=0", swap_pending); end
        checks++; if (swap_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", swap_count); end
        checks++; if (wr_range_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", wr_range_err); end
        checks++; if (vga_color !== 15'h0) begin errors++; $display("FAIL reset_vga_color got=%0h exp=0", vga_color); end
        rst_b = 1;
        cycle();
    endtask

    task automatic test_full_frame();
        for (int a = 0; a < FP; a++) begin
            wen = 1; graphics_addr = AW'(a); graphics_color = 15'h1234;
            cycle();
        end
        wen = 0;
        checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL full_front_before got=%0b exp=0", front_sel); end
        toggle = 1;
        cycle();
        toggle = 0;
        checks++; if (swap_pending !== m_pend || swap_pending !== 1'b1) begin errors++; $display("FAIL full_pending got=%0b exp=1", swap_pending); end
        cycle();
        checks++; if (front_sel !== 1'b1 || m_front !== 1'b1) begin errors++; $display("FAIL full_swap_front got=%0b exp=1", front_sel); end
        checks++; if (swap_count !== 8'd1) begin errors++; $display("FAIL full_swap_count got=%0d exp=1", swap_count); end
        vga_addr = 5;
        cycle();
        cycle();
        checks++; if (vga_color !== 15'h1234 || m_color !== 15'h1234) begin errors++; $display("FAIL full_read5 got=%0h exp=1234", vga_color); end
    endtask

    task automatic test_pending();
        logic [7:0] cnt0;
        bit front0;
        for (int i = 0; i < 100; i++) begin
            wen = 1; graphics_addr = AW'($urandom_range(0, FP - 2)); graphics_color = DW'($urandom);
            cycle();
        end
        wen = 0;
        cnt0 = m_cnt; front0 = m_front;
        toggle = 1; cycle(); toggle = 0; cycle();
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL pend_set got=%0b exp=1", swap_pending); end
        checks++; if (front_sel !== front0) begin errors++; $display("FAIL pend_front_held got=%0b exp=%0b", front_sel, front0); end
        for (int k = 0; k < 2; k++) begin
            toggle = 1; cycle(); toggle = 0; cycle();
        end
        checks++; if (swap_pending !== 1'b1 || swap_count !== cnt0) begin errors++; $display("FAIL pend_absorb pend=%0b cnt=%0d exp=1,%0d", swap_pending, swap_count, cnt0); end
        wen = 1; graphics_addr = AW'(FP - 1); graphics_color = DW'($urandom);
        cycle();
        wen = 0;
        checks++; if (front_sel !== front0) begin errors++; $display("FAIL pend_last_write_front got=%0b exp=%0b", front_sel, front0); end
        cycle();
        checks++; if (front_sel !== !front0 || swap_pending !== 1'b0) begin errors++; $display("FAIL pend_swap front=%0b pend=%0b exp=%0b,0", front_sel, swap_pending, !front0); end
        repeat (4) cycle();
        checks++; if (swap_count !== cnt0 + 8'd1 || m_cnt !== swap_count) begin errors++; $display("FAIL pend_one_swap got=%0d exp=%0d", swap_count, cnt0 + 8'd1); end
    endtask

    task automatic test_range_err();
        wen = 1; graphics_addr = AW'(FP); graphics_color = DW'($urandom);
        #1;
        checks++; if (buffer0_we !== 1'b0 || buffer1_we !== 1'b0) begin errors++; $display("FAIL oor_we got=%0b%0b exp=00", buffer0_we, buffer1_we); end
        cycle();
        checks++; if (wr_range_err !== 1'b1) begin errors++; $display("FAIL oor_err got=%0b exp=1", wr_range_err); end
        graphics_addr = AW'($urandom_range(FP, (1 << AW) - 1));
        #1;
        checks++; if (buffer0_we !== 1'b0 || buffer1_we !== 1'b0) begin errors++; $display("FAIL oor_we_rand got=%0b%0b exp=00", buffer0_we, buffer1_we); end
        cycle();
        for (int i = 0; i < 5; i++) begin
            graphics_addr = AW'($urandom_range(0, 63)); graphics_color = DW'($urandom);
            #1;
            checks++;
            if ((m_front ? buffer0_we : buffer1_we) !== 1'b1 || (m_front ? buffer1_we : buffer0_we) !== 1'b0) begin
                errors++; $display("FAIL legal_we b0=%0b b1=%0b front=%0b", buffer0_we, buffer1_we, m_front);
            end
            cycle();
        end
        wen = 0;
        checks++; if (wr_range_err !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%0b exp=1", wr_range_err); end
    endtask

    task automatic test_reads();
        vga_addr = AW'(40000);
        cycle();
        vga_addr = 0;
        cycle();
        checks++; if (vga_color !== BLANK) begin errors++; $display("FAIL read_blank got=%0h exp=%0h", vga_color, BLANK); end
        for (int a = 0; a < 64; a++) begin
            wen = 1; graphics_addr = AW'(a); graphics_color = DW'($urandom);
            cycle();
        end
        graphics_addr = AW'(FP - 1);
        cycle();
        wen = 0;
        for (int i = 0; i < 40; i++) begin
            vga_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(FP, 70000)) : AW'($urandom_range(0, 63));
            toggle = (i == 10);
            cycle();
            checks++; if (vga_color !== m_color) begin errors++; $display("FAIL read_b2b i=%0d got=%0h exp=%0h", i, vga_color, m_color); end
        end
        toggle = 0;
    endtask

    task automatic test_reset_pending();
        int guard = 0;
        while (m_cnt != 8'd7 && guard < 300) begin
            wen = 1; graphics_addr = AW'(FP - 1); graphics_color = DW'($urandom);
            cycle();
            wen = 0; toggle = 1; cycle();
            toggle = 0; cycle(); cycle();
            guard++;
        end
        toggle = 1; cycle(); toggle = 0; cycle();
        checks++; if (swap_pending !== 1'b1 || swap_count !== 8'd7) begin errors++; $display("FAIL pre_reset pend=%0b cnt=%0d exp=1,7", swap_pending, swap_count); end
        #2;
        rst_b = 0;
        model_reset();
        #1;
        checks++;
        if (front_sel !== 1'b0 || swap_pending !== 1'b0 || swap_count !== 8'd0 || wr_range_err !== 1'b0 || vga_color !== 15'h0) begin
            errors++; $display("FAIL async_reset front=%0b pend=%0b cnt=%0d err=%0b col=%0h exp all 0", front_sel, swap_pending, swap_count, wr_range_err, vga_color);
        end
        @(posedge clk); #1;
        cycle();
        rst_b = 1;
        cycle();
        wen = 1; graphics_addr = AW'(FP - 1); graphics_color = DW'($urandom);
        cycle();
        wen = 0; toggle = 1; cycle();
        toggle = 0; cycle();
        checks++; if (front_sel !== 1'b1 || swap_count !== 8'd1) begin errors++; $display("FAIL post_reset_swap front=%0b cnt=%0d exp=1,1", front_sel, swap_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            wen = $urandom_range(0, 1);
            case ($urandom_range(0, 15))
                0:       graphics_addr = AW'(FP - 1);
                1:       graphics_addr = AW'($urandom_range(FP, (1 << AW) - 1));
                default: graphics_addr = AW'($urandom_range(0, 63));
            endcase
            graphics_color = DW'($urandom);
            toggle   = ($urandom_range(0, 5) == 0);
            vga_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(FP, 90000)) : AW'($urandom_range(0, 63));
            cycle();
            checks++;
            if (front_sel !== m_front || swap_pending !== m_pend || swap_count !== m_cnt ||
                wr_range_err !== m_err || vga_color !== m_color) begin
                errors++;
                $display("FAIL random i=%0d front=%0b/%0b pend=%0b/%0b cnt=%0d/%0d err=%0b/%0b col=%0h/%0h",
                         i, front_sel, m_front, swap_pending, m_pend, swap_count, m_cnt,
                         wr_range_err, m_err, vga_color, m_color);
            end
        end
        wen = 0; toggle = 0;
    endtask

    initial begin
        for (int a = 0; a < FP; a++) begin
            mem0[a] = '0; mem1[a] = '0; rf0[a] = '0; rf1[a] = '0;
        end
        model_reset();
        #1;
        test_reset();
        test_full_frame();
        test_pending();
        test_range_err();
        test_reads();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
